// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: issues one mult/div op to the shared unit, stalls while it iterates, and returns a single writeback beat.
module multdiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int REG_BITS = 5,
  parameter logic [REG_BITS-1:0] RSTATUS_REG = 30,
  parameter logic [WIDTH-1:0] MULT_EXC_CODE = 4,
  parameter logic [WIDTH-1:0] DIV_EXC_CODE = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                is_mult,
  input  logic                is_div,
  input  logic [WIDTH-1:0]    operand_a,
  input  logic [WIDTH-1:0]    operand_b,
  input  logic [REG_BITS-1:0] in_rd,
  input  logic                flush,
  output logic [WIDTH-1:0]    md_operandA,
  output logic [WIDTH-1:0]    md_operandB,
  output logic                ctrl_MULT,
  output logic                ctrl_DIV,
  input  logic [WIDTH-1:0]    md_result,
  input  logic                md_resultRDY,
  input  logic                md_exception,
  output logic                stall,
  output logic                wb_valid,
  output logic [REG_BITS-1:0] wb_rd,
  output logic [WIDTH-1:0]    wb_data,
  output logic                wb_exception
);
  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, wb_data_q, wb_data_d;
  logic [REG_BITS-1:0] rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic mult_q, mult_d, wb_exc_q, wb_exc_d;
  logic accept, capture, active;
  assign accept  = in_valid & (is_mult ^ is_div) & ~flush & ~reset & (state_q == IDLE || state_q == DONE);
  assign active  = (state_q == START || state_q == BUSY) & ~flush;
  // Result is only trusted in BUSY; a stale ready during START belongs to the previous run.
  assign capture = state_q == BUSY & md_resultRDY & ~flush;
  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rd_d      = rd_q;
    mult_d    = mult_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wb_exc_d  = wb_exc_q;
    if (accept) begin
      state_d = START;
      opa_d   = operand_a;
      opb_d   = operand_b;
      rd_d    = in_rd;
      mult_d  = is_mult;
    end else begin
      unique case (state_q)
        START:   state_d = flush ? IDLE : BUSY;
        BUSY:    state_d = flush ? IDLE : (md_resultRDY ? DONE : BUSY);
        default: state_d = IDLE;
      endcase
    end
    if (capture) begin
      wb_rd_d   = md_exception ? RSTATUS_REG : rd_q;
      wb_data_d = md_exception ? (mult_q ? MULT_EXC_CODE : DIV_EXC_CODE) : md_result;
      wb_exc_d  = md_exception;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      rd_q      <= '0;
      mult_q    <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      wb_exc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rd_q      <= rd_d;
      mult_q    <= mult_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      wb_exc_q  <= wb_exc_d;
    end
  end
  assign md_operandA  = opa_q;
  assign md_operandB  = opb_q;
  assign ctrl_MULT    = state_q == START & mult_q & ~flush;
  assign ctrl_DIV     = state_q == START & ~mult_q & ~flush;
  assign stall        = accept | active;
  assign wb_valid     = state_q == DONE;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_exception = wb_exc_q;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: directed scenarios against multdiv_ctrl with the mult/div unit modelled inline.
module tb_multdiv_ctrl;
  logic clock = 0, reset = 1, in_valid = 0, is_mult = 0, is_div = 0, flush = 0;
  logic [31:0] operand_a = 0, operand_b = 0, md_result = 0;
  logic [4:0] in_rd = 0;
  logic md_resultRDY = 0, md_exception = 0;
  logic [31:0] md_operandA, md_operandB, wb_data;
  logic ctrl_MULT, ctrl_DIV, stall, wb_valid, wb_exception;
  logic [4:0] wb_rd;
  int total = 0, bad = 0;

  multdiv_ctrl dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .is_mult(is_mult), .is_div(is_div),
    .operand_a(operand_a), .operand_b(operand_b), .in_rd(in_rd), .flush(flush),
    .md_operandA(md_operandA), .md_operandB(md_operandB), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .md_result(md_result), .md_resultRDY(md_resultRDY), .md_exception(md_exception),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exception(wb_exception)
  );

  always #5 clock = ~clock;

  task automatic drive_op(input logic m, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    in_valid = 1; is_mult = m; is_div = ~m; operand_a = a; operand_b = b; in_rd = rd;
  endtask

  // From the negedge of the START cycle, raise ready lat cycles after the start pulse; returns at the DONE negedge.
  task automatic finish_op(input int lat, input logic [31:0] res, input logic exc);
    repeat (lat) @(negedge clock);
    md_resultRDY = 1; md_exception = exc; md_result = res;
    @(negedge clock);
    md_resultRDY = 0; md_exception = 0;
  endtask

  task automatic run_op(input string nm, input logic m, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input logic exc, input logic [31:0] res,
                        input logic [4:0] exp_rd, input logic [31:0] exp_data, input logic exp_exc);
    int stalls, mp, dp, wbs, ctrl_cyc, i;
    logic opb_bad;
    logic [4:0] got_rd;
    logic [31:0] got_data;
    logic got_exc;
    stalls = 0; mp = 0; dp = 0; wbs = 0; ctrl_cyc = -1; i = 0; opb_bad = 0;
    got_rd = 'x; got_data = 'x; got_exc = 'x;
    drive_op(m, a, b, rd);
    #1;
    if (stall) stalls++;
    forever begin
      @(negedge clock);
      i++;
      in_valid = 0;
      if (stall) stalls++;
      if (stall && md_operandB !== b) opb_bad = 1;
      if (ctrl_MULT) begin mp++; ctrl_cyc = i; end
      if (ctrl_DIV) begin dp++; ctrl_cyc = i; end
      if (wb_valid) begin wbs++; got_rd = wb_rd; got_data = wb_data; got_exc = wb_exception; end
      md_resultRDY = (ctrl_cyc >= 0 && i == ctrl_cyc + lat);
      md_exception = md_resultRDY & exc;
      md_result = res;
      if ((ctrl_cyc >= 0 && i >= ctrl_cyc + lat + 2) || i > 200) break;
    end
    md_resultRDY = 0; md_exception = 0;
    total++; if (i > 200) begin bad++; $display("FAIL %s timeout: cycles=%0d required<=200", nm, i); end
    total++; if (mp !== (m ? 1 : 0) || dp !== (m ? 0 : 1)) begin bad++; $display("FAIL %s start pulses: mult=%0d div=%0d required mult=%0d div=%0d", nm, mp, dp, m ? 1 : 0, m ? 0 : 1); end
    total++; if (stalls !== lat + 2) begin bad++; $display("FAIL %s stall cycles: got=%0d required=%0d", nm, stalls, lat + 2); end
    total++; if (opb_bad !== 0) begin bad++; $display("FAIL %s operandB hold: changed while stalled, required %0d", nm, b); end
    total++; if (wbs !== 1) begin bad++; $display("FAIL %s wb_valid beats: got=%0d required=1", nm, wbs); end
    total++; if (got_rd !== exp_rd || got_data !== exp_data || got_exc !== exp_exc) begin
      bad++; $display("FAIL %s writeback: rd=%0d data=%0d exc=%b required rd=%0d data=%0d exc=%b", nm, got_rd, got_data, got_exc, exp_rd, exp_data, exp_exc);
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if ({stall, ctrl_MULT, ctrl_DIV, wb_valid, wb_exception} !== 5'b0 || md_operandA !== 0 || md_operandB !== 0 || wb_rd !== 0 || wb_data !== 0) begin
      bad++; $display("FAIL reset outputs: stall=%b cm=%b cd=%b wbv=%b opA=%0d opB=%0d wb_data=%0d required all 0", stall, ctrl_MULT, ctrl_DIV, wb_valid, md_operandA, md_operandB, wb_data);
    end
    @(negedge clock); reset = 0;
    @(negedge clock);
  endtask

  task automatic test_ops();
    run_op("mul6x7", 1, 6, 7, 3, 16, 0, 42, 3, 42, 0);
    run_op("div100/7", 0, 100, 7, 9, 33, 0, 14, 9, 14, 0);
    run_op("div5/0", 0, 5, 0, 12, 33, 1, 32'hdead, 30, 5, 1);
    run_op("mulovf", 1, 32'h7fffffff, 2, 6, 16, 1, 32'hfffffffe, 30, 4, 1);
  endtask

  task automatic test_ignored();
    drive_op(1, 1, 1, 2); is_div = 1; #1;
    total++; if (stall !== 0) begin bad++; $display("FAIL both-type stall: got=%b required=0", stall); end
    @(negedge clock); in_valid = 0;
    total++; if (ctrl_MULT !== 0 || ctrl_DIV !== 0) begin bad++; $display("FAIL both-type start: cm=%b cd=%b required 0 0", ctrl_MULT, ctrl_DIV); end
    drive_op(1, 1, 1, 2); flush = 1; #1;
    total++; if (stall !== 0) begin bad++; $display("FAIL flush-idle stall: got=%b required=0", stall); end
    @(negedge clock); in_valid = 0; flush = 0;
    total++; if (ctrl_MULT !== 0 || stall !== 0) begin bad++; $display("FAIL flush-idle accept: cm=%b stall=%b required 0 0", ctrl_MULT, stall); end
  endtask

  task automatic test_flush();
    int wbs;
    drive_op(0, 100, 7, 9);
    @(negedge clock); in_valid = 0;
    repeat (5) @(negedge clock);
    flush = 1; #1;
    total++; if (stall !== 0 || ctrl_DIV !== 0) begin bad++; $display("FAIL flush-busy comb: stall=%b cd=%b required 0 0", stall, ctrl_DIV); end
    @(negedge clock); flush = 0;
    total++; if (stall !== 0 || wb_valid !== 0) begin bad++; $display("FAIL flush-busy next: stall=%b wbv=%b required 0 0", stall, wb_valid); end
    md_resultRDY = 1; md_result = 77;
    @(negedge clock); md_resultRDY = 0;
    wbs = 0;
    repeat (4) begin if (wb_valid || stall) wbs++; @(negedge clock); end
    total++; if (wbs !== 0) begin bad++; $display("FAIL flush late rdy: active cycles=%0d required=0", wbs); end
  endtask

  task automatic test_back_to_back();
    drive_op(1, 2, 5, 1);
    @(negedge clock); in_valid = 0;
    finish_op(4, 10, 0);
    total++; if (wb_valid !== 1 || wb_data !== 10 || wb_rd !== 1) begin bad++; $display("FAIL b2b first wb: v=%b data=%0d rd=%0d required 1 10 1", wb_valid, wb_data, wb_rd); end
    drive_op(1, 3, 3, 4); #1;
    total++; if (stall !== 1) begin bad++; $display("FAIL b2b done stall: got=%b required=1", stall); end
    @(negedge clock); in_valid = 0;
    total++; if (ctrl_MULT !== 1 || wb_valid !== 0 || md_operandA !== 3) begin bad++; $display("FAIL b2b start: cm=%b wbv=%b opA=%0d required 1 0 3", ctrl_MULT, wb_valid, md_operandA); end
    finish_op(4, 9, 0);
    total++; if (wb_valid !== 1 || wb_data !== 9 || wb_rd !== 4 || wb_exception !== 0) begin bad++; $display("FAIL b2b second wb: v=%b data=%0d rd=%0d exc=%b required 1 9 4 0", wb_valid, wb_data, wb_rd, wb_exception); end
    @(negedge clock);
    total++; if (wb_valid !== 0 || wb_data !== 9) begin bad++; $display("FAIL b2b hold: v=%b data=%0d required 0 9", wb_valid, wb_data); end
  endtask

  task automatic test_async_reset();
    drive_op(0, 8, 2, 7);
    @(negedge clock); in_valid = 0;
    repeat (3) @(negedge clock);
    total++; if (stall !== 1) begin bad++; $display("FAIL pre-reset stall: got=%b required=1", stall); end
    #2 reset = 1; #1;
    total++; if (stall !== 0 || ctrl_DIV !== 0 || wb_valid !== 0 || md_operandB !== 0) begin
      bad++; $display("FAIL async reset: stall=%b cd=%b wbv=%b opB=%0d required 0 0 0 0", stall, ctrl_DIV, wb_valid, md_operandB);
    end
    @(negedge clock); reset = 0;
    @(negedge clock);
    run_op("mul2x2", 1, 2, 2, 5, 3, 0, 4, 5, 4, 0);
  endtask

  initial begin
    test_reset();
    test_ops();
    test_ignored();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Issue/collect controller between the execute stage and the shared multiply/divide unit.
- Accepts one mult/div op from execute and latches its operands and destination register.
- Fires a single-cycle start pulse (ctrl_MULT/ctrl_DIV) to the unit and stalls the pipeline while the unit iterates.
- Captures the result or exception and presents one writeback beat; exceptions are redirected to $rstatus (r30).

Parameters:
- WIDTH, 32, operand/result width.
- REG_BITS, 5, register-specifier width.
- RSTATUS_REG, 30, destination used on exception.
- MULT_EXC_CODE, 4, value written to RSTATUS_REG on multiply overflow.
- DIV_EXC_CODE, 5, value written to RSTATUS_REG on divide-by-zero.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  execute stage presents a mult/div op this cycle.
- is_mult  in  1  op is MUL.
- is_div  in  1  op is DIV.
- operand_a  in  WIDTH  multiplicand/dividend.
- operand_b  in  WIDTH  multiplier/divisor.
- in_rd  in  REG_BITS  destination register.
- flush  in  1  abandon in-flight op (branch/jump squash).
- md_operandA  out  WIDTH  latched operand A to the unit.
- md_operandB  out  WIDTH  latched operand B to the unit.
- ctrl_MULT  out  1  multiply start pulse.
- ctrl_DIV  out  1  divide start pulse.
- md_result  in  WIDTH  unit result.
- md_resultRDY  in  1  unit result valid.
- md_exception  in  1  unit exception (mult overflow / div by zero).
- stall  out  1  freeze PC, F/D and D/X latches.
- wb_valid  out  1  writeback beat.
- wb_rd  out  REG_BITS  writeback destination.
- wb_data  out  WIDTH  writeback data.
- wb_exception  out  1  writeback is an exception write.

Behaviour:
- Reset (async): state=IDLE. All outputs 0. Latched operands, rd and op-type 0.
- States: IDLE, START, BUSY, DONE.
- Valid op = in_valid & (is_mult ^ is_div). in_valid with both or neither type bit set is ignored, no state change.
- IDLE or DONE with a valid op (accept cycle T):
  - latch operand_a, operand_b, in_rd and op type at the edge ending T;
  - stall=1 combinationally during T;
  - next state START.
- START (T+1):
  - exactly one of ctrl_MULT/ctrl_DIV =1 for this single cycle, matching the latched type;
  - stall=1; next BUSY;
  - md_resultRDY is ignored in START (the unit's counter is restarting).
- BUSY:
  - stall=1; ctrl_* =0;
  - md_operandA/B hold the latched values unchanged through START and BUSY (the divider reads the divisor every cycle);
  - when md_resultRDY=1: capture md_result and md_exception; next DONE.
- DONE (one cycle):
  - wb_valid=1, stall=0;
  - normal: wb_rd=latched rd, wb_data=captured result, wb_exception=0;
  - on exception: wb_rd=RSTATUS_REG, wb_data=MULT_EXC_CODE or DIV_EXC_CODE by op type, wb_exception=1;
  - next IDLE, or START if a valid op is accepted in the same cycle (back-to-back).
- wb_* fields are registered. wb_rd/wb_data/wb_exception hold their last values when wb_valid=0; the consumer qualifies them with wb_valid.
- Latency: wb_valid asserts the cycle after the first BUSY cycle that samples md_resultRDY=1. Total accept-to-writeback = 2 + unit iteration count cycles.
- flush:
  - in START or BUSY: next IDLE, no wb_valid, ctrl_* forced 0 that cycle, stall=0 that cycle;
  - in IDLE: suppresses acceptance;
  - in DONE: wb_valid still asserts (already committed).
- flush and a valid op in the same IDLE cycle: flush wins, nothing accepted.
- md_resultRDY outside BUSY has no effect.
- Reset mid-operation: immediate IDLE; no wb_valid, stall=0, ctrl_* =0 asynchronously.

Test Plan:
- MUL 6×7, rd=3, unit model RDY 16 cycles after ctrl_MULT -> ctrl_MULT high exactly 1 cycle; stall high 18 cycles; single wb_valid with wb_rd=3, wb_data=42, wb_exception=0.
- DIV 100/7, rd=9, RDY after 33 cycles -> ctrl_DIV single pulse; md_operandB stays 7 throughout BUSY; wb_data=14, wb_rd=9.
- DIV 5/0, unit raises md_exception with RDY -> wb_rd=30, wb_data=5, wb_exception=1. MUL 0x7FFFFFFF×2 with exception -> wb_rd=30, wb_data=4.
- flush asserted 5 cycles into BUSY of a DIV -> IDLE next cycle; no wb_valid ever; a late RDY pulse is ignored; stall=0.
- Back-to-back: second MUL 3×3 (rd=4) presented in the DONE cycle of the first -> first writeback, then START next cycle; second writeback wb_data=9, wb_rd=4.
- Async reset mid-BUSY -> stall, ctrl_* and wb_valid drop to 0 before the next clock edge; a subsequent op 2×2 completes normally with wb_data=4.
